// File: rtl/lutram_pkg.sv
// rtl/lutram_pkg.sv - shared types and slice helpers for the multiport LUTRAM register file
package lutram_pkg;

    typedef enum logic {
        S_INIT  = 1'b0,
        S_READY = 1'b1
    } state_t;

    function automatic int rd_addr_lo(input int port, input int log_depth);
        return port * log_depth;
    endfunction

    function automatic int rd_data_lo(input int port, input int width);
        return port * width;
    endfunction

endpackage

// File: rtl/lutram_bank.sv
// rtl/lutram_bank.sv - one write / one async read LUTRAM bank, no reset on the storage
module lutram_bank #(
    parameter int WIDTH     = 256,
    parameter int DEPTH     = 4,
    parameter int LOG_DEPTH = $clog2(DEPTH)
) (
    input  logic                 clk,
    input  logic                 we,
    input  logic [LOG_DEPTH-1:0] waddr,
    input  logic [WIDTH-1:0]     wdata,
    input  logic [LOG_DEPTH-1:0] raddr,
    output logic [WIDTH-1:0]     rdata
);

    (* ramstyle = "MLAB, no_rw_check" *) logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Caller masks out-of-range addresses; the raw read is left unguarded so it maps to plain LUTRAM.
    assign rdata = mem[raddr];

endmodule

// File: rtl/lutram_multiport.sv
// rtl/lutram_multiport.sv - 1W/NUM_RD-R register file built from replicated banks,
// with a self-timed zeroing sweep, optional registered reads and write bypass.
module lutram_multiport
    import lutram_pkg::*;
#(
    parameter int WIDTH        = 256,
    parameter int DEPTH        = 4,
    parameter int LOG_DEPTH    = $clog2(DEPTH),
    parameter int NUM_RD       = 2,
    parameter int READ_LATENCY = 0,
    parameter int WR_BYPASS    = 1
) (
    input  logic                        CLK,
    input  logic                        CLR,
    input  logic                        clr_start,
    input  logic                        wen,
    input  logic [LOG_DEPTH-1:0]        waddr,
    input  logic [WIDTH-1:0]            din,
    input  logic [NUM_RD*LOG_DEPTH-1:0] raddr,
    output logic [NUM_RD*WIDTH-1:0]     dout,
    output logic                        init_busy,
    output logic                        wr_err
);

    localparam logic [LOG_DEPTH-1:0] LAST_ADDR = LOG_DEPTH'(DEPTH - 1);
    localparam logic [LOG_DEPTH:0]   DEPTH_EXT = (LOG_DEPTH + 1)'(DEPTH);

    state_t                 state, state_nxt;
    logic [LOG_DEPTH-1:0]   clr_cnt, clr_cnt_nxt;
    logic                   busy;
    logic                   waddr_ok;
    logic                   wr_ok;
    logic                   bank_we;
    logic [LOG_DEPTH-1:0]   bank_waddr;
    logic [WIDTH-1:0]       bank_wdata;

    always_ff @(posedge CLK or posedge CLR) begin
        if (CLR) begin
            state   <= S_INIT;
            clr_cnt <= '0;
            wr_err  <= 1'b0;
        end else begin
            state   <= state_nxt;
            clr_cnt <= clr_cnt_nxt;
            wr_err  <= wen & ~wr_ok;
        end
    end

    // A clr_start seen mid-sweep restarts from address 0 rather than extending the current pass.
    always_comb begin
        state_nxt   = state;
        clr_cnt_nxt = clr_cnt;
        case (state)
            S_INIT: begin
                if (clr_start) begin
                    clr_cnt_nxt = '0;
                end else if (clr_cnt == LAST_ADDR) begin
                    clr_cnt_nxt = '0;
                    state_nxt   = S_READY;
                end else begin
                    clr_cnt_nxt = clr_cnt + LOG_DEPTH'(1);
                end
            end
            S_READY: begin
                if (clr_start) begin
                    state_nxt   = S_INIT;
                    clr_cnt_nxt = '0;
                end
            end
        endcase
    end

    assign busy       = (state == S_INIT);
    assign init_busy  = busy;
    assign waddr_ok   = ({1'b0, waddr} < DEPTH_EXT);
    assign wr_ok      = (state == S_READY) && wen && waddr_ok;
    assign bank_we    = busy | wr_ok;
    assign bank_waddr = busy ? clr_cnt : waddr;
    assign bank_wdata = busy ? '0 : din;

    for (genvar gi = 0; gi < NUM_RD; gi++) begin : g_rd
        logic [LOG_DEPTH-1:0] ra;
        logic                 ra_ok;
        logic [WIDTH-1:0]     rd_mem;

        assign ra    = raddr[rd_addr_lo(gi, LOG_DEPTH) +: LOG_DEPTH];
        assign ra_ok = ({1'b0, ra} < DEPTH_EXT);

        lutram_bank #(
            .WIDTH    (WIDTH),
            .DEPTH    (DEPTH),
            .LOG_DEPTH(LOG_DEPTH)
        ) u_bank (
            .clk  (CLK),
            .we   (bank_we),
            .waddr(bank_waddr),
            .wdata(bank_wdata),
            .raddr(ra),
            .rdata(rd_mem)
        );

        if (READ_LATENCY == 0) begin : g_comb
            assign dout[rd_data_lo(gi, WIDTH) +: WIDTH] = (busy || !ra_ok) ? '0 : rd_mem;
        end else begin : g_reg
            logic [WIDTH-1:0] q;

            always_ff @(posedge CLK or posedge CLR) begin
                if (CLR) begin
                    q <= '0;
                end else if (busy || !ra_ok) begin
                    q <= '0;
                end else if ((WR_BYPASS != 0) && wr_ok && (waddr == ra)) begin
                    q <= din;
                end else begin
                    q <= rd_mem;
                end
            end

            assign dout[rd_data_lo(gi, WIDTH) +: WIDTH] = q;
        end
    end

endmodule

// File: tb/tb_lutram_multiport.sv
// tb/tb_lutram_multiport.sv - three configurations driven in parallel against an
// array-level reference model, plus directed scenarios with literal expectations.
module tb_lutram_multiport;

    localparam int W = 256;

    logic           CLK = 1'b0;
    logic           CLR;
    logic           clr_start;
    logic           wen;
    logic [2:0]     waddr;
    logic [W-1:0]   din;
    logic [5:0]     raddr;
    logic [2*W-1:0] dout [3];
    logic           busy [3];
    logic           err  [3];

    int n_chk  = 0;
    int n_fail = 0;

    always #5 CLK = ~CLK;

    // u0: DEPTH=4 comb read; u1: DEPTH=5 registered+bypass; u2: DEPTH=5 registered, no bypass
    lutram_multiport #(.WIDTH(W), .DEPTH(4), .NUM_RD(2), .READ_LATENCY(0), .WR_BYPASS(1)) u0 (
        .CLK(CLK), .CLR(CLR), .clr_start(clr_start), .wen(wen), .waddr(waddr[1:0]), .din(din),
        .raddr({raddr[4:3], raddr[1:0]}), .dout(dout[0]), .init_busy(busy[0]), .wr_err(err[0]));
    lutram_multiport #(.WIDTH(W), .DEPTH(5), .NUM_RD(2), .READ_LATENCY(1), .WR_BYPASS(1)) u1 (
        .CLK(CLK), .CLR(CLR), .clr_start(clr_start), .wen(wen), .waddr(waddr), .din(din),
        .raddr(raddr), .dout(dout[1]), .init_busy(busy[1]), .wr_err(err[1]));
    lutram_multiport #(.WIDTH(W), .DEPTH(5), .NUM_RD(2), .READ_LATENCY(1), .WR_BYPASS(0)) u2 (
        .CLK(CLK), .CLR(CLR), .clr_start(clr_start), .wen(wen), .waddr(waddr), .din(din),
        .raddr(raddr), .dout(dout[2]), .init_busy(busy[2]), .wr_err(err[2]));

    function automatic int dep(input int k);
        return (k == 0) ? 4 : 5;
    endfunction

    function automatic bit lat(input int k);
        return k != 0;
    endfunction

    function automatic bit byp(input int k);
        return k != 2;
    endfunction

    function automatic int wad(input int k);
        return (k == 0) ? int'(waddr[1:0]) : int'(waddr);
    endfunction

    function automatic int rad(input int k, input int p);
        logic [2:0] a;
        a = raddr[p*3 +: 3];
        return (k == 0) ? int'(a[1:0]) : int'(a);
    endfunction

    task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Model: left[k] = busy cycles still to come; the array reads as all-zero once a sweep ends.
    int           left [3];
    logic [W-1:0] mem  [3][8];
    logic [W-1:0] rreg [3][2];
    logic         merr [3];

    task automatic model_reset();
        for (int k = 0; k < 3; k++) begin
            left[k] = dep(k);
            merr[k] = 1'b0;
            rreg[k][0] = '0;
            rreg[k][1] = '0;
        end
    endtask

    task automatic model_step();
        for (int k = 0; k < 3; k++) begin
            int wa;
            int ra;
            bit bsy;
            bit acc;
            wa  = wad(k);
            bsy = left[k] > 0;
            acc = !bsy && wen && (wa < dep(k));
            for (int p = 0; p < 2; p++) begin
                ra = rad(k, p);
                if (bsy || ra >= dep(k))         rreg[k][p] = '0;
                else if (byp(k) && acc && wa == ra) rreg[k][p] = din;
                else                             rreg[k][p] = mem[k][ra];
            end
            merr[k] = wen && !acc;
            if (acc) mem[k][wa] = din;
            if (bsy) for (int a = 0; a < 8; a++) mem[k][a] = '0;
            if (clr_start)        left[k] = dep(k);
            else if (left[k] > 0) left[k] = left[k] - 1;
        end
    endtask

    always @(posedge CLK or posedge CLR) begin
        if (CLR) model_reset();
        else     model_step();
    end

    always @(negedge CLK) begin
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("busy_u%0d", k), W'(busy[k]), W'(left[k] > 0));
            chk($sformatf("wr_err_u%0d", k), W'(err[k]), W'(merr[k]));
            for (int p = 0; p < 2; p++) begin
                logic [W-1:0] exp;
                if (lat(k))                              exp = rreg[k][p];
                else if (left[k] > 0 || rad(k, p) >= dep(k)) exp = '0;
                else                                     exp = mem[k][rad(k, p)];
                chk($sformatf("dout_u%0d_p%0d", k, p), dout[k][p*W +: W], exp);
            end
        end
    end

    task automatic step();
        @(posedge CLK);
        #2;
    endtask

    initial begin
        int c0;
        int c1;
        for (int k = 0; k < 3; k++)
            for (int a = 0; a < 8; a++) mem[k][a] = '0;
        CLR = 1'b0; clr_start = 1'b0; wen = 1'b0; waddr = '0; din = '0;
        raddr = {3'd3, 3'd3};
        #1 CLR = 1'b1;
        repeat (3) step();
        CLR = 1'b0;

        // sweep length after reset release
        c0 = 0; c1 = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge CLK);
            c0 += int'(busy[0]);
            c1 += int'(busy[1]);
            step();
        end
        chk("sweep_len_d4", W'(c0), W'(4));
        chk("sweep_len_d5", W'(c1), W'(5));

        // two writes, combinational read on both ports
        wen = 1'b1; waddr = 3'd1; din = W'('hA5); step();
        waddr = 3'd2; din = W'('h5A); step();
        wen = 1'b0; raddr = {3'd2, 3'd1};
        @(negedge CLK);
        chk("comb_rd_p0", dout[0][W-1:0], W'('hA5));
        chk("comb_rd_p1", dout[0][2*W-1:W], W'('h5A));

        // same-cycle write/read: bypass vs old data
        wen = 1'b1; waddr = 3'd2; din = W'('h77); raddr = {3'd0, 3'd2};
        step();
        wen = 1'b0;
        @(negedge CLK);
        chk("bypass_on", dout[1][W-1:0], W'('h77));
        chk("bypass_off", dout[2][W-1:0], W'('h5A));

        // out-of-range write on DEPTH=5
        wen = 1'b1; waddr = 3'd5; din = W'('hEE); raddr = {3'd1, 3'd5};
        step();
        wen = 1'b0;
        @(negedge CLK);
        chk("oob_err_u1", W'(err[1]), W'(1));
        chk("oob_err_u2", W'(err[2]), W'(1));
        chk("oob_rd_zero", dout[1][W-1:0], W'(0));
        chk("oob_keep_a1", dout[1][2*W-1:W], W'('hA5));
        step();
        @(negedge CLK);
        chk("oob_err_pulse", W'(err[1]), W'(0));

        // fill, then double clr_start
        for (int a = 0; a < 5; a++) begin
            wen = 1'b1; waddr = 3'(a); din = W'(a + 16); step();
        end
        wen = 1'b0; clr_start = 1'b1; step();
        clr_start = 1'b0; step();
        clr_start = 1'b1; step();
        clr_start = 1'b0;
        c0 = 0; c1 = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge CLK);
            c0 += int'(busy[0]);
            c1 += int'(busy[1]);
            step();
        end
        chk("restart_len_d4", W'(c0), W'(4));
        chk("restart_len_d5", W'(c1), W'(5));
        for (int a = 0; a < 4; a++) begin
            raddr = {3'(a), 3'(a)};
            @(negedge CLK);
            chk($sformatf("cleared_a%0d", a), dout[0][W-1:0] | dout[0][2*W-1:W], W'(0));
            step();
        end

        // async CLR, then CLR mid-sweep, then a write dropped during the sweep
        wen = 1'b1; waddr = 3'd3; din = W'('h33); raddr = {3'd3, 3'd3}; step();
        wen = 1'b0; step();
        @(negedge CLK);
        chk("pre_clr_rd", dout[1][W-1:0], W'('h33));
        step();
        CLR = 1'b1;
        #1;
        chk("async_busy", W'(busy[1]), W'(1));
        chk("async_dout", dout[1][W-1:0], W'(0));
        step();
        CLR = 1'b0;
        step(); step();
        CLR = 1'b1;
        #1;
        chk("mid_sweep_busy", W'(busy[1]), W'(1));
        step();
        CLR = 1'b0;
        c0 = 0; c1 = 0;
        for (int i = 0; i < 8; i++) begin
            if (i == 1) begin
                wen = 1'b1; waddr = 3'd3; din = W'('hFF);
            end else begin
                wen = 1'b0;
            end
            @(negedge CLK);
            c0 += int'(busy[0]);
            c1 += int'(busy[1]);
            if (i == 2) chk("sweep_wr_err", W'(err[1]), W'(1));
            if (i == 3) chk("sweep_wr_err_end", W'(err[1]), W'(0));
            step();
        end
        chk("reclr_len_d4", W'(c0), W'(4));
        chk("reclr_len_d5", W'(c1), W'(5));
        raddr = {3'd3, 3'd3};
        step();
        @(negedge CLK);
        chk("dropped_wr_u1", dout[1][W-1:0], W'(0));
        chk("dropped_wr_u0", dout[0][W-1:0], W'(0));
        step();

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            CLR       = ($urandom_range(0, 499) == 0);
            clr_start = ($urandom_range(0, 79) == 0);
            wen       = 1'($urandom_range(0, 1));
            waddr     = 3'($urandom_range(0, 7));
            raddr     = 6'($urandom);
            for (int j = 0; j < 8; j++) din[j*32 +: 32] = $urandom;
            step();
        end
        CLR = 1'b0; clr_start = 1'b0; wen = 1'b0;
        step();
        @(negedge CLK);
        #1;

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/lutram_multiport.md
Name: lutram_multiport

Overview:
Parametrised MLAB-style register file with one write port and NUM_RD independent read ports. Each read port is a replicated LUTRAM bank.
Replaces the "long synchronous reset" clear with a self-timed clear sequencer: one address zeroed per cycle after reset or on request, with a busy flag.
Adds optional registered read outputs, write-to-read bypass and a dropped-write error flag.
Used as small queue-state or context tables inside the DUA hardware pipeline.

Parameters:
WIDTH, 256, data word width in bits
DEPTH, 4, entries per bank; any value >=2, not required to be a power of two
LOG_DEPTH, $clog2(DEPTH), address width
NUM_RD, 2, number of read ports / replicated banks (>=1)
READ_LATENCY, 0, 0 = combinational read, 1 = registered read
WR_BYPASS, 1, applies only when READ_LATENCY=1; 1 = same-cycle write forwarded to the read

Ports:
CLK  in  1  clock
CLR  in  1  reset; asynchronous, active-high
clr_start  in  1  pulse: re-zero whole array
wen  in  1  write enable
waddr  in  LOG_DEPTH  write address
din  in  WIDTH  write data
raddr  in  NUM_RD*LOG_DEPTH  read addresses; port i uses bits [i*LOG_DEPTH +: LOG_DEPTH]
dout  out  NUM_RD*WIDTH  read data; port i uses bits [i*WIDTH +: WIDTH]
init_busy  out  1  clear sweep in progress
wr_err  out  1  one-cycle pulse: a write was dropped

Behaviour:
- Reset: clock is CLK, reset is CLR, asynchronous, active-high. Reset is applied to control state only; the array itself is never reset.
- Reset values: FSM=S_INIT, clr_cnt=0, init_busy=1, wr_err=0, registered dout=0.
- FSM states: S_INIT, S_READY.
  - S_INIT: every bank gets address clr_cnt written with 0 each cycle.
    - clr_cnt increments by 1.
    - When clr_cnt==DEPTH-1, the zero write happens, clr_cnt returns to 0 and the FSM goes to S_READY the next cycle.
    - A sweep takes exactly DEPTH cycles after CLR deasserts.
  - S_READY: init_busy=0. clr_start=1 returns the FSM to S_INIT with clr_cnt=0 on the next edge.
  - clr_start asserted in S_INIT restarts the sweep (clr_cnt=0). It never extends the sweep beyond DEPTH cycles from the last clr_start.
- Writes:
  - Accepted only in S_READY with wen=1 and waddr<DEPTH. The write lands in all NUM_RD banks at the same edge.
  - wen=1 while in S_INIT, or with waddr>=DEPTH, is dropped. wr_err=1 on the following cycle only.
  - In S_READY, wen and clr_start in the same cycle: the write is performed, then the sweep begins next cycle.
- Reads:
  - READ_LATENCY=0: dout_i = bank_i[raddr_i] combinationally. Forced to 0 while init_busy=1. Read-during-write returns old contents (no_rw_check semantics).
  - READ_LATENCY=1: dout_i is registered at the edge after raddr_i is presented. It registers 0 if init_busy=1 in the sample cycle.
    - WR_BYPASS=1 and an accepted write with waddr==raddr_i in the same cycle: dout_i = din.
    - WR_BYPASS=0 in that case: dout_i = old contents.
  - raddr_i>=DEPTH: dout_i = 0.
- CLR asserted mid-sweep or mid-operation: immediate return to reset values. The array is re-zeroed by the subsequent sweep.

Decomposition:
- Package lutram_pkg:
  - FSM state typedef (S_INIT, S_READY).
  - Helper localparams for port-slice offsets.
- Sub-module lutram_bank: one write port, one read port, ramstyle "MLAB, no_rw_check", no reset.
  - Instantiated NUM_RD times by a generate loop.
  - The top level holds the FSM, the write muxing (sweep vs user), bypass/masking and the output registers.

Test Plan:
- Default params. Release CLR, hold raddr=3. -> init_busy=1 for exactly 4 cycles, dout=0 throughout; init_busy=0 on cycle 5.
- READ_LATENCY=0. Write 0xA5 to addr 1 and 0x5A to addr 2, then read raddr0=1, raddr1=2. -> dout0=0xA5, dout1=0x5A in the same cycle.
- READ_LATENCY=1, WR_BYPASS=1. wen with waddr=2, din=0x77, with raddr0=2 in the same cycle. -> dout0=0x77 next cycle. Repeat with WR_BYPASS=0. -> dout0 = prior value.
- wen during sweep (cycle 2 after CLR release). -> wr_err pulses for 1 cycle; a later read of that address returns 0. waddr=5 with DEPTH=5 -> wr_err pulse, no bank changes.
- Fill all entries, pulse clr_start, pulse again 2 cycles later. -> init_busy=1 for DEPTH cycles after the second pulse; all reads return 0 afterward.
- Assert CLR for 1 cycle mid-sweep while READ_LATENCY=1. -> dout=0, init_busy=1 asynchronously; a full DEPTH-cycle sweep follows.
